// File: rtl/rxn_pkg.sv
// Shared types and constants for the reaction-timer engine: FSM states,
// VGA face codes and the LFSR feedback polynomial.
package rxn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ARMED,
    ST_HIT,
    ST_FOUL,
    ST_TIMEOUT
  } state_t;

  localparam logic [2:0] FACE_SMILE   = 3'b011;
  localparam logic [2:0] FACE_PIRATE  = 3'b100;
  localparam logic [2:0] FACE_DISCO   = 3'b101;
  localparam logic [2:0] FACE_FOUL    = 3'b110;
  localparam logic [2:0] FACE_TIMEOUT = 3'b111;

  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [2:0] face_of(input state_t s);
    case (s)
      ST_ARMED:   face_of = FACE_PIRATE;
      ST_HIT:     face_of = FACE_DISCO;
      ST_FOUL:    face_of = FACE_FOUL;
      ST_TIMEOUT: face_of = FACE_TIMEOUT;
      default:    face_of = FACE_SMILE;
    endcase
  endfunction

endpackage

// File: rtl/rxn_lfsr.sv
// 16-bit Galois LFSR, one step per enabled clk; the state is registered with no
// extra latency and there is no backpressure beyond the enable.
module rxn_lfsr
  import rxn_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/rxn_timer_core.sv
// Reaction timer: random delay, one-hot lamp, ms response measurement, best time.
// A button press is resolved on the following clk edge; inputs are never stalled.
module rxn_timer_core
  import rxn_pkg::*;
#(
  parameter int          TICK_DIV     = 100000,
  parameter int          N_CH         = 8,
  parameter int          TIME_W       = 16,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          DELAY_W      = 11,
  parameter int          TIMEOUT_MS   = 5000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_go,
  input  logic              i_clr_best,
  input  logic [N_CH-1:0]   i_a,
  output logic [N_CH-1:0]   o_lamp,
  output logic [2:0]        o_face,
  output logic [TIME_W-1:0] o_rxn_ms,
  output logic [TIME_W-1:0] o_best_ms,
  output logic              o_valid,
  output logic              o_foul,
  output logic              o_timeout,
  output logic              o_busy,
  output logic [7:0]        o_hit_cnt
);

  localparam int TGT_W  = $clog2(N_CH);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t            r_state, w_state_nxt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [TIME_W-1:0] r_dly, r_cnt, r_rxn_ms, r_best_ms;
  logic [TGT_W-1:0]  r_tgt;
  logic              r_valid;
  logic [7:0]        r_hit_cnt;
  logic [15:0]       w_lfsr;
  logic              w_unused_lfsr;
  logic              w_tick, w_hit, w_enter_wait, w_enter_armed;
  logic [N_CH-1:0]   w_tgt_oh;
  logic [TIME_W-1:0] w_cnt_inc;

  rxn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr;
  assign w_tick        = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
  assign w_tgt_oh      = N_CH'(1) << r_tgt;
  assign w_cnt_inc     = r_cnt + TIME_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_lamp      = '0;
    o_face      = face_of(r_state);
    o_busy      = (r_state == ST_WAIT) || (r_state == ST_ARMED);
    o_foul      = (r_state == ST_FOUL);
    o_timeout   = (r_state == ST_TIMEOUT);
    case (r_state)
      ST_WAIT: begin
        if (|i_a) begin
          w_state_nxt = ST_FOUL;
        end else if (w_tick && (r_dly <= TIME_W'(1))) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        o_lamp = w_tgt_oh;
        // Any stray bit fouls, even alongside the correct one.
        if (|(i_a & ~w_tgt_oh)) begin
          w_state_nxt = ST_FOUL;
        end else if (i_a == w_tgt_oh) begin
          w_state_nxt = ST_HIT;
        end else if (w_tick && (w_cnt_inc == TIME_W'(TIMEOUT_MS))) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      default: begin
        if (i_go && (i_a == '0)) begin
          w_state_nxt = ST_WAIT;
        end
      end
    endcase
  end

  assign w_enter_wait  = (r_state != ST_WAIT)  && (w_state_nxt == ST_WAIT);
  assign w_enter_armed = (r_state != ST_ARMED) && (w_state_nxt == ST_ARMED);
  assign w_hit         = (r_state == ST_ARMED) && (w_state_nxt == ST_HIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_dly      <= '0;
      r_tgt      <= '0;
      r_cnt      <= '0;
      r_rxn_ms   <= '0;
      r_best_ms  <= '1;
      r_valid    <= 1'b0;
      r_hit_cnt  <= '0;
    end else begin
      if (w_enter_wait || w_enter_armed || w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end

      if (w_enter_wait) begin
        r_dly <= TIME_W'(MIN_DELAY_MS) + TIME_W'(w_lfsr[DELAY_W-1:0]);
        r_tgt <= w_lfsr[15 -: TGT_W];
      end else if ((r_state == ST_WAIT) && w_tick) begin
        r_dly <= r_dly - TIME_W'(1);
      end

      if (w_enter_armed) begin
        r_cnt <= '0;
      end else if ((r_state == ST_ARMED) && w_tick) begin
        r_cnt <= w_cnt_inc;
      end

      r_valid <= w_hit;
      if (w_hit) begin
        r_rxn_ms  <= r_cnt;
        r_hit_cnt <= r_hit_cnt + 8'd1;
      end

      // A clear in the same cycle as a hit discards that hit's time.
      if (i_clr_best) begin
        r_best_ms <= '1;
      end else if (w_hit && (r_cnt < r_best_ms)) begin
        r_best_ms <= r_cnt;
      end
    end
  end

  assign o_rxn_ms  = r_rxn_ms;
  assign o_best_ms = r_best_ms;
  assign o_valid   = r_valid;
  assign o_hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_rxn_timer_core.sv
// Directed bench for rxn_timer_core with small timing parameters; hit results are
// queued at press time and checked by a monitor on each valid pulse.
module tb_rxn_timer_core;

  localparam int          TICK_DIV     = 4;
  localparam int          N_CH         = 4;
  localparam int          TIME_W       = 16;
  localparam int          MIN_DELAY_MS = 2;
  localparam int          DELAY_W      = 2;
  localparam int          TIMEOUT_MS   = 10;
  localparam logic [15:0] SEED         = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0;
  logic              clr_best = 1'b0;
  logic [N_CH-1:0]   a = '0;
  logic [N_CH-1:0]   lamp;
  logic [2:0]        face;
  logic [TIME_W-1:0] rxn_ms, best_ms;
  logic              valid, foul, timeout, busy;
  logic [7:0]        hit_cnt;

  rxn_timer_core #(
    .TICK_DIV(TICK_DIV), .N_CH(N_CH), .TIME_W(TIME_W), .MIN_DELAY_MS(MIN_DELAY_MS),
    .DELAY_W(DELAY_W), .TIMEOUT_MS(TIMEOUT_MS), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_clr_best(clr_best), .i_a(a),
    .o_lamp(lamp), .o_face(face), .o_rxn_ms(rxn_ms), .o_best_ms(best_ms),
    .o_valid(valid), .o_foul(foul), .o_timeout(timeout), .o_busy(busy),
    .o_hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rxn;
    logic [15:0] best;
    logic [7:0]  hit;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [15:0] m_lfsr;

  // Reference LFSR, stepped from the polynomial x^16+x^14+x^13+x^11+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] rxn, input logic [15:0] best, input logic [7:0] hit);
    exp_t e;
    e.rxn = rxn; e.best = best; e.hit = hit;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk("rxn_ms", 32'(rxn_ms), 32'(m_e.rxn));
        chk("best_ms", 32'(best_ms), 32'(m_e.best));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_e.hit));
      end
    end
  end

  task automatic do_go(output int tgt, output int dly);
    @(negedge clk);
    go  = 1'b1;
    tgt = int'(m_lfsr[15:14]);
    dly = MIN_DELAY_MS + int'(m_lfsr[1:0]);
    if (dly == 0) dly = 1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_lamp(input int tgt, input int dly);
    int c;
    logic [N_CH-1:0] oh;
    c  = 0;
    oh = N_CH'(1) << tgt;
    while (lamp == '0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("lamp_delay", 32'(c), 32'(4 * dly));
    chk("lamp_onehot", 32'(lamp), 32'(oh));
    chk("face_armed", 32'(face), 32'h4);
  endtask

  task automatic press(input logic [N_CH-1:0] mask, input int ms, input logic clr);
    if (ms > 0) begin
      repeat (4 * ms) @(posedge clk);
      @(negedge clk);
    end
    a = mask;
    clr_best = clr;
    @(negedge clk);
    a = '0;
    clr_best = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, dly;
    logic [N_CH-1:0] oh, other;

    repeat (3) @(negedge clk);
    chk("rst_face", 32'(face), 32'h3);
    chk("rst_lamp", 32'(lamp), 32'h0);
    chk("rst_best", 32'(best_ms), 32'hFFFF);
    chk("rst_rxn", 32'(rxn_ms), 32'h0);
    chk("rst_hit", 32'(hit_cnt), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("lfsr_nonzero", 32'(dut.w_lfsr != 16'h0), 32'h1);
    end
    chk("lfsr_model", 32'(dut.w_lfsr), 32'(m_lfsr));
    chk("idle_face", 32'(face), 32'h3);
    chk("idle_lamp", 32'(lamp), 32'h0);
    chk("idle_best", 32'(best_ms), 32'hFFFF);

    // Start with a button held must be ignored.
    @(negedge clk); a = 4'b0001; go = 1'b1;
    @(negedge clk); a = '0; go = 1'b0;
    chk("go_held_busy", 32'(busy), 32'h0);

    // Round 1: hit after 3 ms.
    do_go(tgt, dly);
    chk("wait_busy", 32'(busy), 32'h1);
    chk("wait_face", 32'(face), 32'h3);
    wait_lamp(tgt, dly);
    oh = N_CH'(1) << tgt;
    push_exp(16'd3, 16'd3, 8'd1);
    press(oh, 3, 1'b0);
    chk("hit_face", 32'(face), 32'h5);
    chk("hit_lamp", 32'(lamp), 32'h0);
    @(negedge clk);
    chk("valid_one_cycle", 32'(valid), 32'h0);

    // Round 2: immediate press reports 0; coincident clear wins for best.
    do_go(tgt, dly);
    wait_lamp(tgt, dly);
    oh = N_CH'(1) << tgt;
    push_exp(16'd0, 16'hFFFF, 8'd2);
    press(oh, 0, 1'b1);

    // Round 3: hit after 5 ms, then a standalone clear.
    do_go(tgt, dly);
    wait_lamp(tgt, dly);
    oh = N_CH'(1) << tgt;
    push_exp(16'd5, 16'd5, 8'd3);
    press(oh, 5, 1'b0);
    clr_best = 1'b1;
    @(negedge clk); clr_best = 1'b0;
    chk("clr_best", 32'(best_ms), 32'hFFFF);
    chk("clr_keeps_rxn", 32'(rxn_ms), 32'd5);

    // False start during WAIT.
    do_go(tgt, dly);
    a = 4'b0010;
    @(negedge clk); a = '0;
    chk("wait_foul_face", 32'(face), 32'h6);
    chk("wait_foul_flag", 32'(foul), 32'h1);
    chk("wait_foul_lamp", 32'(lamp), 32'h0);

    // Wrong channel while ARMED.
    do_go(tgt, dly);
    wait_lamp(tgt, dly);
    other = N_CH'(1) << ((tgt + 1) % N_CH);
    press(other, 1, 1'b0);
    chk("wrong_foul_face", 32'(face), 32'h6);
    chk("wrong_foul_lamp", 32'(lamp), 32'h0);

    // Target together with another button.
    do_go(tgt, dly);
    wait_lamp(tgt, dly);
    oh    = N_CH'(1) << tgt;
    other = N_CH'(1) << ((tgt + 1) % N_CH);
    press(oh | other, 2, 1'b0);
    chk("multi_foul_face", 32'(face), 32'h6);
    chk("multi_foul_flag", 32'(foul), 32'h1);

    // Timeout after exactly TIMEOUT_MS ticks in ARMED.
    do_go(tgt, dly);
    wait_lamp(tgt, dly);
    repeat (4 * TIMEOUT_MS - 1) @(negedge clk);
    chk("pre_timeout_face", 32'(face), 32'h4);
    @(negedge clk);
    chk("timeout_face", 32'(face), 32'h7);
    chk("timeout_flag", 32'(timeout), 32'h1);
    chk("timeout_lamp", 32'(lamp), 32'h0);
    chk("timeout_rxn", 32'(rxn_ms), 32'd5);
    a = 4'b0100; go = 1'b1;
    @(negedge clk); a = '0; go = 1'b0;
    chk("timeout_go_held", 32'(face), 32'h7);

    // Asynchronous reset while ARMED.
    do_go(tgt, dly);
    wait_lamp(tgt, dly);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_lamp", 32'(lamp), 32'h0);
    chk("arst_face", 32'(face), 32'h3);
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_rxn", 32'(rxn_ms), 32'h0);
    chk("arst_hit", 32'(hit_cnt), 32'h0);
    chk("arst_best", 32'(best_ms), 32'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_face", 32'(face), 32'h3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rxn_timer_core.md
Name: rxn_timer_core

Overview:
- Parametrised reaction-timer engine for the pseudo-terminal game.
- On `go`, waits a pseudo-random delay, then lights one of N_CH target lamps and measures the response time in milliseconds.
- Detects false starts, wrong-channel presses and timeouts, and tracks the best time.
- Drives a face code for the VGA front end and a ms result for the stopwatch/display path.

Parameters:
- TICK_DIV, 100000: clk cycles per ms tick (100 MHz clock).
- N_CH, 8: number of response inputs and target lamps; power of two, 2..16.
- TIME_W, 16: width of the ms counters.
- MIN_DELAY_MS, 1000: fixed part of the random delay.
- DELAY_W, 11: width of the random delay addend (0..2^DELAY_W-1 ms).
- TIMEOUT_MS, 5000: ARMED duration before timeout; must be less than 2^TIME_W-1.
- LFSR_SEED, 16'hACE1: nonzero LFSR reset value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  start request, sampled each clk.
- clr_best  in  1  clears best_ms to all-ones.
- a  in  N_CH  response buttons; synchronous and debounced upstream.
- lamp  out  N_CH  one-hot target indicator.
- face  out  3  face code to the VGA block.
- rxn_ms  out  TIME_W  last valid reaction time.
- best_ms  out  TIME_W  minimum valid reaction time.
- valid  out  1  one-cycle pulse when rxn_ms updates.
- foul  out  1  high while in FOUL.
- timeout  out  1  high while in TIMEOUT.
- busy  out  1  high in WAIT or ARMED.
- hit_cnt  out  8  count of valid hits; wraps at 255 to 0.

Behaviour:
- Reset values (reset low):
  - state IDLE; lamp 0; face 3'b011; rxn_ms 0; best_ms all-ones; valid 0; foul 0; timeout 0; busy 0; hit_cnt 0.
  - LFSR = LFSR_SEED; tick counter 0.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clk in every state; never holds 0.
- ms tick:
  - Counter runs 0..TICK_DIV-1 and pulses tick at TICK_DIV-1.
  - Counter is cleared on entry to WAIT and on entry to ARMED, so the first tick lands exactly TICK_DIV cycles after entry.
- States and face codes: IDLE 011, WAIT 011, ARMED 100, HIT 101, FOUL 110, TIMEOUT 111.
- IDLE, HIT, FOUL, TIMEOUT:
  - If go=1 and a==0, go to WAIT.
  - On that transition, load dly = MIN_DELAY_MS + lfsr[DELAY_W-1:0].
  - Also capture tgt = lfsr[15 -: log2(N_CH)].
  - If go=1 while a!=0, ignore the start.
  - rxn_ms, best_ms and hit_cnt persist across rounds.
- WAIT:
  - Any a bit high → FOUL next cycle.
  - Otherwise dly decrements on each tick; at a tick with dly==1, go to ARMED.
  - On entry to ARMED: lamp[tgt]=1, cnt=0.
  - MIN_DELAY_MS=0 with addend 0 counts as 1 ms.
- ARMED:
  - Priority 1: a has any bit other than tgt set → FOUL. This includes tgt pressed together with another bit.
  - Priority 2: a==onehot(tgt) → HIT. rxn_ms=cnt and valid=1 for one cycle. best_ms=min(best_ms,cnt). hit_cnt+1.
  - Priority 3: on tick, cnt+1; when cnt reaches TIMEOUT_MS → TIMEOUT.
  - Latency: a sampled at edge t produces the state, rxn_ms and valid at edge t+1.
  - Presses within the first ms report 0.
- Lamp timing: lamp clears on the same edge that leaves ARMED.
- go in WAIT or ARMED: ignored; no abort.
- clr_best:
  - Takes effect the next cycle in any state.
  - If clr_best coincides with a HIT, clear wins: best_ms = all-ones, while rxn_ms still updates.
- Reset mid-round: immediate return to reset values; no valid pulse.
- busy = (state==WAIT)|(state==ARMED); foul and timeout decode the state directly.

Decomposition:
- Package rxn_pkg:
  - State enum.
  - Face codes FACE_SMILE=3'b011, FACE_PIRATE=3'b100, FACE_DISCO=3'b101, FACE_FOUL=3'b110, FACE_TIMEOUT=3'b111.
  - LFSR tap constant.
- Sub-module rxn_lfsr (seed param, enable, 16-bit state out), reusable by danger generation elsewhere.
- Tick divider and FSM stay inline.

Test Plan:
Sim params TICK_DIV=4, N_CH=4, MIN_DELAY_MS=2, DELAY_W=2, TIMEOUT_MS=10.
- Reset low then high, hold idle 20 cycles → face=011, lamp=0, best_ms=FFFF, hit_cnt=0, LFSR never 0.
- go pulse, wait for lamp one-hot, press the matching a bit 3 ticks (12 cycles) after lamp rises → next cycle face=101, rxn_ms=3, valid one cycle, best_ms=3, hit_cnt=1.
- Second round, correct press after 5 ms → rxn_ms=5, best_ms stays 3; then clr_best → best_ms=FFFF.
- go, then press any a during WAIT → FOUL next cycle, face=110, lamp never lit; a different bit than target in ARMED → FOUL; target plus another bit → FOUL, no valid.
- go, no press → after 10 ticks in ARMED, face=111, timeout=1, lamp=0, rxn_ms unchanged; go with a held → remains TIMEOUT.
- Assert reset while ARMED → lamp=0, face=011, valid stays 0, rxn_ms=0 immediately (asynchronous).
